decode_stage: RTL
=================

# decode_stage

Second pipeline stage of the mini-rv core: consumes the instruction word and PC produced by the fetch stage, decodes RV32I, reads the 32×32 register file, and registers operands, immediate and control fields into the ID/EX pipeline register. It owns the write-back port of the register file. It detects load-use hazards, driving `stall` back to fetch, and squashes wrong-path instructions on a taken branch from EX.

## Interface
Parameters:
- `RESET_PC`, 32'h0: PC value loaded into `id_ex_pc` on reset and on bubbles.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_id_instr_data`  in  32  instruction word, aligned with `if_id_pc`.
- `if_id_pc`  in  32  PC of `if_id_instr_data`.
- `ex_if_take_branch`  in  1  taken branch/jump resolved in EX this cycle.
- `wb_id_we`, `wb_id_rd`, `wb_id_data`  in  1/5/32  register-file write port.
- `stall`  out  1  load-use hazard; freezes fetch and the PC.
- `id_ex_valid`  out  1  ID/EX holds a real instruction.
- `id_ex_pc`, `id_ex_rs1_data`, `id_ex_rs2_data`, `id_ex_imm`  out  32 each.
- `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd`  out  5 each  register indices, for EX forwarding.
- `id_ex_alu_op`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- `id_ex_alu_src_imm`, `id_ex_alu_src_pc`  out  1 each  ALU B = imm; ALU A = PC.
- `id_ex_mem_read`, `id_ex_mem_write`  out  1 each.
- `id_ex_funct3`  out  3  load/store width or branch condition.
- `id_ex_branch`, `id_ex_jal`, `id_ex_jalr`, `id_ex_reg_write`  out  1 each.
- `id_ex_wb_sel`  out  2  0 ALU, 1 memory, 2 PC+4.
- `id_illegal`  out  1  registered one-cycle pulse: an unrecognised opcode was squashed.

## Operation
- Decode: full RV32I base (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP). FENCE and SYSTEM decode as NOP, with valid=1 and no side effects. Any other opcode produces a bubble and pulses `id_illegal`.
- Immediates: I, S, B, J sign-extended from bit 31; U = {instr[31:12], 12'b0}. Shift-immediates use instr[24:20]; instr[30] selects SRA/SUB.
- LUI: PASS_B with the immediate. AUIPC: ADD with src_pc and src_imm. JAL/JALR: wb_sel=2.
- Register file: x0 always reads 0, and writes to x0 are ignored. Write occurs on the rising edge when `wb_id_we`=1. Read is combinational.
- `reg_write` is forced to 0 when rd=0.
- Load-use hazard: `id_ex_valid && id_ex_mem_read && id_ex_rd!=0`, and id_ex_rd equals rs1 or rs2 of the current instruction.
  - Only source fields actually used by the format are compared: U/J types compare none; I/LOAD/JALR compare rs1 only.
- Hazard response: `stall`=1 combinationally, ID/EX loads a bubble, and the ID input is held by fetch. This costs exactly one bubble.
- Flush:
  - When `ex_if_take_branch`=1, ID/EX loads a bubble at this edge and at the next edge, tracked by a registered `flush_q`.
  - Rationale: the wrong-path instruction is in ID now, and fetch latches one more wrong-path PC at the same edge.
- Priority: rst > flush (`ex_if_take_branch` or `flush_q`) > hazard > normal. `stall` is forced to 0 while flushing.
- Bubble contents:
  - valid, reg_write, mem_read, mem_write, branch, jal, jalr are 0.
  - All other fields are 0; pc = `RESET_PC`.

## Timing
- Latency: one cycle from `if_id_*` to `id_ex_*`.
- `stall` and decode logic are combinational from `if_id_instr_data` and the ID/EX register. There is no path from `stall` back into decode.
- Reset (synchronous): every `id_ex_*` field = bubble value, `flush_q`=0, `id_illegal`=0. Register file contents are NOT reset.
- rst asserted mid-stall or mid-flush: the next cycle is a bubble with `flush_q`=0 and `stall`=0.
- A write-back and a read of the same register in the same cycle behave as defined under Configuration.

## Configuration
- `MINI_RV_RF_BYPASS_EN` defined: read ports return `wb_id_data` when `wb_id_we` is set, rd matches, and rd!=0 (write-through).
- Undefined: the read returns the old register value. The pipeline then needs an external WB→ID forward or one extra cycle of separation.

## Test plan
- Reset, then feed `addi x1,x0,5` (0x00500093) at pc 0 -> next cycle `id_ex_valid`=1, imm=5, rd=1, alu_op=ADD, alu_src_imm=1, reg_write=1.
- WB writes x2=0xDEADBEEF, then `add x3,x2,x2` -> rs1_data=rs2_data=0xDEADBEEF. Same-cycle write/read returns the new value only with `MINI_RV_RF_BYPASS_EN`.
- `lw x5,0(x1)` followed by `add x6,x5,x0` -> `stall`=1 for one cycle, one bubble, then add issued with rs1=5.
- `lw x5,…` followed by `lui x5,1` -> no stall (U-type does not read rs1).
- `ex_if_take_branch` pulse during a stall -> `stall`=0, two consecutive bubbles, then the target instruction is valid.
- Opcode 7'b1111111 -> bubble, `id_illegal`=1 for one cycle; any write to x0 -> a later read of x0 returns 0.

Source files
------------

// File: rtl/decode_stage.sv
// mini-rv ID stage: RV32I decode, 32x32 register file, load-use stall and branch squash into ID/EX.
// Define MINI_RV_RF_BYPASS_EN to make register reads write-through from the WB port.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr_data,
  input  logic [31:0] if_id_pc,
  input  logic        ex_if_take_branch,
  input  logic        wb_id_we,
  input  logic [4:0]  wb_id_rd,
  input  logic [31:0] wb_id_data,
  output logic        stall,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [3:0]  id_ex_alu_op,
  output logic        id_ex_alu_src_imm,
  output logic        id_ex_alu_src_pc,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_branch,
  output logic        id_ex_jal,
  output logic        id_ex_jalr,
  output logic        id_ex_reg_write,
  output logic [1:0]  id_ex_wb_sel,
  output logic        id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  logic [31:0] rf [32];
  logic        flush_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

  logic        valid_p0, illegal_p0, use_rs1_p0, use_rs2_p0, has_rd_p0;
  logic signed [31:0] imm_p0;
  logic [3:0]  alu_op_p0;
  logic        src_imm_p0, src_pc_p0, mem_read_p0, mem_write_p0;
  logic        branch_p0, jal_p0, jalr_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  wb_sel_p0;
  logic [4:0]  rs1_p0, rs2_p0, rd_p0;
  logic [31:0] rs1_data_p0, rs2_data_p0;
  logic        flush, hazard_p0, load_p0;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef MINI_RV_RF_BYPASS_EN
    if (wb_id_we && wb_id_rd == idx) return wb_id_data;
`endif
    return rf[idx];
  endfunction

  assign opcode = if_id_instr_data[6:0];
  assign f3     = if_id_instr_data[14:12];
  assign imm_i  = {{20{if_id_instr_data[31]}}, if_id_instr_data[31:20]};
  assign imm_s  = {{20{if_id_instr_data[31]}}, if_id_instr_data[31:25], if_id_instr_data[11:7]};
  assign imm_b  = {{19{if_id_instr_data[31]}}, if_id_instr_data[31], if_id_instr_data[7],
                   if_id_instr_data[30:25], if_id_instr_data[11:8], 1'b0};
  assign imm_j  = {{11{if_id_instr_data[31]}}, if_id_instr_data[31], if_id_instr_data[19:12],
                   if_id_instr_data[20], if_id_instr_data[30:21], 1'b0};
  assign imm_u  = {if_id_instr_data[31:12], 12'b0};
  assign imm_sh = {27'b0, if_id_instr_data[24:20]};

  always_comb begin
    valid_p0     = 1'b1;
    illegal_p0   = 1'b0;
    use_rs1_p0   = 1'b0;
    use_rs2_p0   = 1'b0;
    has_rd_p0    = 1'b0;
    imm_p0       = '0;
    alu_op_p0    = ALU_ADD;
    src_imm_p0   = 1'b0;
    src_pc_p0    = 1'b0;
    mem_read_p0  = 1'b0;
    mem_write_p0 = 1'b0;
    branch_p0    = 1'b0;
    jal_p0       = 1'b0;
    jalr_p0      = 1'b0;
    funct3_p0    = 3'b0;
    wb_sel_p0    = 2'd0;
    case (opcode)
      OPC_LUI: begin
        has_rd_p0 = 1'b1; imm_p0 = imm_u; alu_op_p0 = ALU_PASS_B; src_imm_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        has_rd_p0 = 1'b1; imm_p0 = imm_u; src_imm_p0 = 1'b1; src_pc_p0 = 1'b1;
      end
      OPC_JAL: begin
        has_rd_p0 = 1'b1; imm_p0 = imm_j; src_imm_p0 = 1'b1; src_pc_p0 = 1'b1;
        jal_p0 = 1'b1; wb_sel_p0 = 2'd2;
      end
      OPC_JALR: begin
        has_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; imm_p0 = imm_i; src_imm_p0 = 1'b1;
        jalr_p0 = 1'b1; wb_sel_p0 = 2'd2;
      end
      OPC_BRANCH: begin
        use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; imm_p0 = imm_b; alu_op_p0 = ALU_SUB;
        branch_p0 = 1'b1; funct3_p0 = f3;
      end
      OPC_LOAD: begin
        has_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; imm_p0 = imm_i; src_imm_p0 = 1'b1;
        mem_read_p0 = 1'b1; funct3_p0 = f3; wb_sel_p0 = 2'd1;
      end
      OPC_STORE: begin
        use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; imm_p0 = imm_s; src_imm_p0 = 1'b1;
        mem_write_p0 = 1'b1; funct3_p0 = f3;
      end
      OPC_OPIMM: begin
        // only the shift-right form uses bit 30; ADDI never becomes SUB
        has_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; src_imm_p0 = 1'b1;
        imm_p0 = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
        alu_op_p0 = alu_from_f3(f3, (f3 == 3'b101) && if_id_instr_data[30]);
      end
      OPC_OP: begin
        has_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1;
        alu_op_p0 = alu_from_f3(f3, if_id_instr_data[30]);
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: begin
        valid_p0 = 1'b0; illegal_p0 = 1'b1;
      end
    endcase
  end

  assign rs1_p0      = use_rs1_p0 ? if_id_instr_data[19:15] : 5'd0;
  assign rs2_p0      = use_rs2_p0 ? if_id_instr_data[24:20] : 5'd0;
  assign rd_p0       = has_rd_p0 ? if_id_instr_data[11:7] : 5'd0;
  assign rs1_data_p0 = rf_read(rs1_p0);
  assign rs2_data_p0 = rf_read(rs2_p0);

  assign hazard_p0 = id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     ((use_rs1_p0 && id_ex_rd == if_id_instr_data[19:15]) ||
                      (use_rs2_p0 && id_ex_rd == if_id_instr_data[24:20]));
  assign flush   = ex_if_take_branch || flush_q;
  assign stall   = hazard_p0 && !flush && !rst;
  assign load_p0 = !rst && !flush && !hazard_p0 && valid_p0;

  always_ff @(posedge clk) begin
    if (wb_id_we && wb_id_rd != 5'd0) rf[wb_id_rd] <= wb_id_data;
  end

  // ID/EX boundary: every non-load cycle (reset, flush, hazard, illegal) writes a bubble
  always_ff @(posedge clk) begin
    flush_q           <= !rst && ex_if_take_branch;
    id_illegal        <= !rst && !flush && illegal_p0;
    id_ex_valid       <= load_p0;
    id_ex_pc          <= load_p0 ? if_id_pc : RESET_PC;
    id_ex_rs1_data    <= load_p0 ? rs1_data_p0 : 32'h0;
    id_ex_rs2_data    <= load_p0 ? rs2_data_p0 : 32'h0;
    id_ex_imm         <= load_p0 ? imm_p0 : 32'h0;
    id_ex_rs1         <= load_p0 ? rs1_p0 : 5'd0;
    id_ex_rs2         <= load_p0 ? rs2_p0 : 5'd0;
    id_ex_rd          <= load_p0 ? rd_p0 : 5'd0;
    id_ex_alu_op      <= load_p0 ? alu_op_p0 : ALU_ADD;
    id_ex_alu_src_imm <= load_p0 && src_imm_p0;
    id_ex_alu_src_pc  <= load_p0 && src_pc_p0;
    id_ex_mem_read    <= load_p0 && mem_read_p0;
    id_ex_mem_write   <= load_p0 && mem_write_p0;
    id_ex_funct3      <= load_p0 ? funct3_p0 : 3'd0;
    id_ex_branch      <= load_p0 && branch_p0;
    id_ex_jal         <= load_p0 && jal_p0;
    id_ex_jalr        <= load_p0 && jalr_p0;
    id_ex_reg_write   <= load_p0 && has_rd_p0 && (rd_p0 != 5'd0);
    id_ex_wb_sel      <= load_p0 ? wb_sel_p0 : 2'd0;
  end

endmodule
